// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver.
// Two-flop line synchroniser, start-bit glitch rejection, configurable data
// width / parity / stop bits, framing and parity checking, and a one-entry
// valid/ready holding register with a sticky overrun flag.
module uart_rx_param #(
    parameter int CLK_DIV    = 10417,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(DATA_BITS);

    // Counter value at which the start bit is re-checked (mid start bit)
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    // Counter value at which every later bit is sampled (one bit period on)
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic             ODD_BIT   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic                 stop_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 frame_pend_r;
    logic                 parity_pend_r;
    logic                 commit_r;
    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 rx_prev_r;
    logic                 load_s;
    logic                 drop_s;

    // XOR reduction of the received data word
    function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
        return ^word;
    endfunction

    // Synchronise the asynchronous line and keep one cycle of history for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Frame FSM: bit timing, shifting, error accumulation and the commit pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            busy          <= 1'b0;
            cnt_r         <= '0;
            bit_idx_r     <= '0;
            stop_idx_r    <= 1'b0;
            shift_r       <= '0;
            frame_pend_r  <= 1'b0;
            parity_pend_r <= 1'b0;
            commit_r      <= 1'b0;
        end else if (!ena) begin
            // Disabled: abandon any frame in progress without reporting it
            state_r  <= ST_IDLE;
            busy     <= 1'b0;
            cnt_r    <= '0;
            commit_r <= 1'b0;
        end else begin
            commit_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rx_prev_r && !rx_sync_r) begin
                        state_r <= ST_START;
                        busy    <= 1'b1;
                        cnt_r   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt_r == HALF_LAST) begin
                        if (rx_sync_r) begin
                            // Line back high mid start bit: treat as noise
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            state_r       <= ST_DATA;
                            cnt_r         <= '0;
                            bit_idx_r     <= '0;
                            frame_pend_r  <= 1'b0;
                            parity_pend_r <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_r == BIT_LAST) begin
                        shift_r <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
                        cnt_r   <= '0;
                        if (bit_idx_r == LAST_IDX) begin
                            stop_idx_r <= 1'b0;
                            if (PARITY_EN != 0) begin
                                state_r <= ST_PARITY;
                            end else begin
                                state_r <= ST_STOP;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (cnt_r == BIT_LAST) begin
                        parity_pend_r <= parity_of(shift_r) ^ rx_sync_r ^ ODD_BIT;
                        state_r       <= ST_STOP;
                        cnt_r         <= '0;
                        stop_idx_r    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r        <= '0;
                        frame_pend_r <= frame_pend_r | ~rx_sync_r;
                        if (stop_idx_r == LAST_STOP) begin
                            // Next cycle is the commit cycle for the holding register
                            state_r  <= ST_IDLE;
                            busy     <= 1'b0;
                            commit_r <= 1'b1;
                        end else begin
                            stop_idx_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Decide whether a committing frame is loaded or dropped as an overrun
    always_comb begin
        load_s = 1'b0;
        drop_s = 1'b0;
        if (commit_r) begin
            if (!data_valid || data_ready) begin
                load_s = 1'b1;
                drop_s = 1'b0;
            end else begin
                load_s = 1'b0;
                drop_s = 1'b1;
            end
        end else begin
            load_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Holding register with valid/ready handshake and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load_s) begin
                data_out   <= shift_r;
                frame_err  <= frame_pend_r;
                parity_err <= parity_pend_r;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end else begin
                data_valid <= data_valid;
            end
            if (drop_s) begin
                overrun <= 1'b1;
            end else begin
                overrun <= overrun;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed testbench for uart_rx_param: three instances (8N1, 8E1, 8N2) at
// CLK_DIV=16 share clock, reset, enable and data_ready; the serial line is
// steered to one instance at a time.
module tb_uart_rx_param;

    localparam int DIV = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b1;
    logic line = 1'b1;
    logic data_ready = 1'b0;
    int   sel = 0;
    int   checks = 0;
    int   failures = 0;

    logic rx_a, rx_p, rx_t;
    logic [7:0] a_data, p_data, t_data;
    logic a_valid, a_fe, a_pe, a_ov, a_busy;
    logic p_valid, p_fe, p_pe, p_ov, p_busy;
    logic t_valid, t_fe, t_pe, t_ov, t_busy;

    assign rx_a = (sel == 0) ? line : 1'b1;
    assign rx_p = (sel == 1) ? line : 1'b1;
    assign rx_t = (sel == 2) ? line : 1'b1;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .ena(ena), .rx(rx_a), .data_out(a_data), .data_valid(a_valid),
        .data_ready(data_ready), .frame_err(a_fe), .parity_err(a_pe), .overrun(a_ov), .busy(a_busy));

    uart_rx_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_p (
        .clk(clk), .rst(rst), .ena(ena), .rx(rx_p), .data_out(p_data), .data_valid(p_valid),
        .data_ready(data_ready), .frame_err(p_fe), .parity_err(p_pe), .overrun(p_ov), .busy(p_busy));

    uart_rx_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_t (
        .clk(clk), .rst(rst), .ena(ena), .rx(rx_t), .data_out(t_data), .data_valid(t_valid),
        .data_ready(data_ready), .frame_err(t_fe), .parity_err(t_pe), .overrun(t_ov), .busy(t_busy));

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; line = 1'b1; data_ready = 1'b0; ena = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ready();
        @(negedge clk);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    // Drive one frame. ready_at: cycle index where data_ready is high for one cycle.
    // abort_at: cycle index where rst (kind 0) or ena=0 (kind 1) is applied for one cycle,
    // after which the task returns right away.
    task automatic send_frame(input int sel_i, input logic [7:0] d, input logic has_par,
                              input logic par_bit, input int nstop, input logic [1:0] stops,
                              input int ready_at, input int abort_at, input int abort_kind);
        logic [15:0] v;
        int n;
        sel = sel_i;
        v = 16'hFFFF;
        v[0] = 1'b0;
        v[8:1] = d;
        n = 9;
        if (has_par) begin v[n] = par_bit; n++; end
        v[n] = stops[0]; n++;
        if (nstop == 2) begin v[n] = stops[1]; n++; end
        for (int c = 0; c < n * DIV; c++) begin
            @(negedge clk);
            if (c == abort_at) begin
                line = 1'b1;
                if (abort_kind == 0) rst = 1'b1; else ena = 1'b0;
                @(negedge clk);
                rst = 1'b0; ena = 1'b1; data_ready = 1'b0;
                return;
            end
            line = v[c / DIV];
            data_ready = (c == ready_at);
        end
        @(negedge clk);
        line = 1'b1; data_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (a_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", a_data); end
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_valid); end
        checks++; if (a_fe !== 1'b0 || a_pe !== 1'b0) begin failures++; $display("FAIL reset_errs got=%b%b exp=00", a_fe, a_pe); end
        checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", a_ov); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    endtask

    task automatic test_basic();
        do_reset();
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 2'b11, -1, -1, 0);
        checks++; if (a_data !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", a_data); end
        checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", a_valid); end
        checks++; if (a_fe !== 1'b0 || a_pe !== 1'b0) begin failures++; $display("FAIL basic_errs got=%b%b exp=00", a_fe, a_pe); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", a_busy); end
        idle(20);
        checks++; if (a_valid !== 1'b1 || a_data !== 8'hA5) begin failures++; $display("FAIL basic_hold got=%b/%h exp=1/a5", a_valid, a_data); end
        pulse_ready();
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL basic_consume got=%b exp=0", a_valid); end
    endtask

    task automatic test_glitch();
        do_reset();
        sel = 0;
        @(negedge clk); line = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_start got=%b exp=1", a_busy); end
        line = 1'b1;
        idle(20);
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_end got=%b exp=0", a_busy); end
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%b exp=0", a_valid); end
        checks++; if (a_fe !== 1'b0 || a_pe !== 1'b0) begin failures++; $display("FAIL glitch_errs got=%b%b exp=00", a_fe, a_pe); end
    endtask

    task automatic test_parity();
        do_reset();
        send_frame(1, 8'h3C, 1'b1, 1'b1, 1, 2'b11, -1, -1, 0);
        checks++; if (p_data !== 8'h3C) begin failures++; $display("FAIL parity_bad_data got=%h exp=3c", p_data); end
        checks++; if (p_pe !== 1'b1) begin failures++; $display("FAIL parity_bad_flag got=%b exp=1", p_pe); end
        checks++; if (p_fe !== 1'b0) begin failures++; $display("FAIL parity_bad_fe got=%b exp=0", p_fe); end
        pulse_ready();
        send_frame(1, 8'h3C, 1'b1, 1'b0, 1, 2'b11, -1, -1, 0);
        checks++; if (p_valid !== 1'b1 || p_data !== 8'h3C) begin failures++; $display("FAIL parity_good_data got=%b/%h exp=1/3c", p_valid, p_data); end
        checks++; if (p_pe !== 1'b0) begin failures++; $display("FAIL parity_good_flag got=%b exp=0", p_pe); end
    endtask

    task automatic test_framing();
        do_reset();
        send_frame(0, 8'h7F, 1'b0, 1'b0, 1, 2'b00, -1, -1, 0);
        checks++; if (a_data !== 8'h7F || a_valid !== 1'b1) begin failures++; $display("FAIL frame_data got=%b/%h exp=1/7f", a_valid, a_data); end
        checks++; if (a_fe !== 1'b1) begin failures++; $display("FAIL frame_flag got=%b exp=1", a_fe); end
        checks++; if (a_pe !== 1'b0) begin failures++; $display("FAIL frame_pe got=%b exp=0", a_pe); end
        send_frame(2, 8'h7F, 1'b0, 1'b0, 2, 2'b01, -1, -1, 0);
        checks++; if (t_data !== 8'h7F) begin failures++; $display("FAIL stop2_data got=%h exp=7f", t_data); end
        checks++; if (t_fe !== 1'b1) begin failures++; $display("FAIL stop2_flag got=%b exp=1", t_fe); end
        pulse_ready();
        send_frame(2, 8'h81, 1'b0, 1'b0, 2, 2'b11, -1, -1, 0);
        checks++; if (t_data !== 8'h81 || t_valid !== 1'b1) begin failures++; $display("FAIL stop2_good_data got=%b/%h exp=1/81", t_valid, t_data); end
        checks++; if (t_fe !== 1'b0) begin failures++; $display("FAIL stop2_good_flag got=%b exp=0", t_fe); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(0, 8'hC1, 1'b0, 1'b0, 1, 2'b11, -1, -1, 0);
        send_frame(0, 8'h99, 1'b0, 1'b0, 1, 2'b11, -1, -1, 0);
        checks++; if (a_data !== 8'hC1) begin failures++; $display("FAIL overrun_data got=%h exp=c1", a_data); end
        checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL overrun_valid got=%b exp=1", a_valid); end
        checks++; if (a_ov !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", a_ov); end
        do_reset();
        checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL overrun_reset got=%b exp=0", a_ov); end
        send_frame(0, 8'hC1, 1'b0, 1'b0, 1, 2'b11, -1, -1, 0);
        send_frame(0, 8'h99, 1'b0, 1'b0, 1, 2'b11, 155, -1, 0);
        checks++; if (a_data !== 8'h99) begin failures++; $display("FAIL swap_data got=%h exp=99", a_data); end
        checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL swap_valid got=%b exp=1", a_valid); end
        checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL swap_overrun got=%b exp=0", a_ov); end
    endtask

    task automatic test_reset_mid();
        send_frame(0, 8'h42, 1'b0, 1'b0, 1, 2'b11, -1, 60, 0);
        checks++; if (a_data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", a_data); end
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", a_valid); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", a_busy); end
        idle(200);
        checks++; if (a_valid !== 1'b0 || a_busy !== 1'b0) begin failures++; $display("FAIL midrst_nodeliver got=%b%b exp=00", a_valid, a_busy); end
    endtask

    task automatic test_enable();
        do_reset();
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1, 2'b11, -1, -1, 0);
        send_frame(0, 8'h42, 1'b0, 1'b0, 1, 2'b11, -1, 60, 1);
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL ena_abort_busy got=%b exp=0", a_busy); end
        checks++; if (a_valid !== 1'b1 || a_data !== 8'h5A) begin failures++; $display("FAIL ena_hold got=%b/%h exp=1/5a", a_valid, a_data); end
        idle(200);
        checks++; if (a_data !== 8'h5A || a_ov !== 1'b0) begin failures++; $display("FAIL ena_nodeliver got=%h/%b exp=5a/0", a_data, a_ov); end
        @(negedge clk); ena = 1'b0;
        pulse_ready();
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL ena_consume got=%b exp=0", a_valid); end
        ena = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_framing();
        test_back_to_back();
        test_reset_mid();
        test_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver. It generalises the fixed 8N1 serial front end feeding the cipher core: data width, parity mode, stop-bit count and baud divisor are all configurable. It adds start-bit glitch rejection, framing and parity checking, and overrun detection. Recovered words are delivered to the downstream core over a one-entry valid/ready holding register.

Parameters:
CLK_DIV, 10417, clock cycles per bit (100 MHz / 9600 baud); minimum 4.
DATA_BITS, 8, data bits per frame, 5..9, sent LSB first.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits checked, 1 or 2.

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
ena  in  1  receiver enable
rx  in  1  asynchronous serial line, idle high
data_out  out  DATA_BITS  received word
data_valid  out  1  holding register full
data_ready  in  1  consumer accepts the word
frame_err  out  1  a stop bit sampled 0 for the held word
parity_err  out  1  parity mismatch for the held word
overrun  out  1  sticky: a completed frame was dropped
busy  out  1  FSM not in IDLE

Behaviour:
- rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s. The synchroniser resets to 1.
- Reset (rst=1 at a clk edge):
  - All outputs go to 0, data_out goes to 0, FSM goes to IDLE, baud counter goes to 0.
  - Reset mid-frame aborts the frame with no delivery.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On an rx_s falling edge (previous 1, current 0) with ena=1 -> START, counter cleared.
- START:
  - At counter = CLK_DIV/2 - 1 (integer division), sample rx_s.
  - If 1 -> IDLE (glitch, nothing reported).
  - If 0 -> DATA, counter cleared, bit index 0.
- DATA:
  - Every CLK_DIV cycles (counter = CLK_DIV-1) sample rx_s into the shift register, LSB first.
  - After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
- PARITY:
  - One sample after CLK_DIV cycles.
  - Error when (XOR of data bits) ^ sampled bit ^ PARITY_ODD != 0.
- STOP:
  - STOP_BITS samples, CLK_DIV cycles apart.
  - Any stop sample of 0 sets the pending frame error.
  - The cycle after the last stop sample is the commit cycle; FSM -> IDLE.
- Commit cycle:
  - If data_valid=0, or data_ready=1 in that same cycle: on the next edge data_out, frame_err and parity_err load and data_valid=1.
  - Otherwise the new frame is discarded, the held word is unchanged, and overrun is set. overrun clears only on rst.
- Handshake:
  - data_valid=1 and data_ready=1 at an edge -> data_valid=0, unless a commit loads in the same edge (simultaneous consume and load; no overrun).
  - data_out, frame_err and parity_err stay stable while data_valid=1.
- Frames with errors are still delivered, with their flags set.
- ena=0:
  - FSM forced to IDLE next edge; any frame in progress is aborted silently.
  - The holding register, data_valid and overrun are retained; consumption via data_ready still works.
- IDLE re-arm requires rx_s to be high for at least one cycle before a new falling edge.
- Data-bit sample k is taken CLK_DIV/2 + (k+1)*CLK_DIV cycles after the rx_s falling edge.
- busy = (state != IDLE).

Test Plan:
- CLK_DIV=16, 8N1, send 0xA5 with a valid stop bit, data_ready=0 -> data_out=0xA5, data_valid=1, frame_err=0, parity_err=0, data_valid stays high until data_ready pulses.
- Low pulse on rx of 4 cycles (< CLK_DIV/2) -> FSM returns to IDLE, busy drops, no data_valid, no errors.
- PARITY_EN=1, PARITY_ODD=0, send 0x3C with parity bit 1 (wrong) -> data_out=0x3C, parity_err=1. Resend with parity 0 -> parity_err=0.
- Send 0x7F with stop bit 0 -> frame_err=1, data_out=0x7F. STOP_BITS=2 with second stop bit 0 -> frame_err=1.
- Send 0xC1 then 0x99, data_ready held 0 -> data_out stays 0xC1, overrun=1. Repeat with data_ready=1 only in the commit cycle of 0x99 -> data_out=0x99, overrun stays 0.
- Assert rst during the DATA state of 0x42 -> all outputs 0 next cycle, no delivery. Assert ena=0 mid-frame -> abort, held word and data_valid retained.
